mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage load/store controller; sits between the EX/MEM pipeline register
//  and the data memory. Drives memory transfers with a valid/ready handshake,
//  byte-aligns read data, and stalls the pipeline until the transfer completes.
//  Outputs feed the downstream load sign/zero-extension stage: ld_data and ld_func3.
// PARAMETERS
//  TIMEOUT_CYC  16  max cycles mem_req stays high without mem_ready; 0 = no timeout
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  req_valid  in   1   EX/MEM carries a memory op this cycle
//  is_load    in   1   op is a load (exactly one of is_load/is_store when req_valid)
//  is_store   in   1   op is a store
//  func3      in   3   000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are load-only)
//  addr       in   32  byte address
//  wdata      in   32  store data, right-justified
//  stall      out  1   freeze upstream pipeline
//  resp_valid out  1   1-cycle pulse: op finished OK
//  err        out  1   1-cycle pulse: misaligned, illegal func3, or timeout
//  ld_data    out  32  raw read word shifted right by 8*addr[1:0]
//  ld_func3   out  3   latched func3 for the extension stage
//  mem_req    out  1   memory request valid
//  mem_we     out  1   1 = write
//  mem_addr   out  32  {addr[31:2],2'b00}
//  mem_wdata  out  32  lane-replicated store data
//  mem_wstrb  out  4   byte enables (0 on reads)
//  mem_ready  in   1   memory accepts/completes the request this cycle
//  mem_rdata  in   32  read data, valid when mem_req & mem_ready & !mem_we
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0, ld_func3 = 3'b000; any
//   in-flight mem_req drops at once and is not resumed.
//  FSM states: IDLE, BUSY, RESP.
//  IDLE, req_valid=1 — check the op:
//   - illegal: func3 in {011,110,111}, or a store with func3 100/101
//   - misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=0
//   - illegal or misaligned: err pulses the next cycle; no memory access;
//     state stays IDLE; stall=0.
//   - otherwise: latch addr/func3/op/wdata; go to BUSY; stall=1 combinationally
//     from this cycle on.
//  BUSY: mem_req=1 with registered, stable mem_we/mem_addr/mem_wdata/mem_wstrb.
//   Transfer = mem_req & mem_ready in the same cycle.
//   - On transfer: a load captures mem_rdata >> (8*addr[1:0]) into ld_data;
//     go to RESP.
//   - Cycle counter starts at 1 in the first BUSY cycle. If TIMEOUT_CYC!=0 and
//     the counter reaches TIMEOUT_CYC without a transfer: mem_req drops, err
//     pulses, go to IDLE.
//   - A transfer in the timeout cycle wins; no err.
//  RESP: resp_valid=1 for exactly one cycle; stall=0; ld_data/ld_func3 hold
//   until the next accepted load; then IDLE.
//  Minimum latency: accept -> BUSY(mem_ready=1) -> RESP = resp_valid 2 cycles
//   after acceptance.
//  req_valid during BUSY/RESP is ignored; the pipeline is stalled or advancing.
//  Store lanes:
//   - sb: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}
//   - sh: wstrb = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}
//   - sw: wstrb = 4'b1111
//  A store never updates ld_data. mem_we=0 outside BUSY.
// TESTING
//  1. lw addr=0x100, mem_ready on first BUSY cycle, rdata=0xDEADBEEF -> mem_addr=0x100,
//     resp_valid 2 cycles after accept, ld_data=0xDEADBEEF, ld_func3=010.
//  2. lbu addr=0x103, rdata=0x80AA5511 -> ld_data=0x00000080, wstrb=0, we=0.
//  3. sh addr=0x202, wdata=0x0000ABCD -> mem_addr=0x200, wstrb=1100,
//     mem_wdata=0xABCDABCD, ld_data unchanged.
//  4. lw addr=0x101 -> err pulse, mem_req never asserts, stall stays 0.
//  5. lh, mem_ready held 0, TIMEOUT_CYC=4 -> mem_req high 4 cycles, then err, IDLE;
//     repeat with mem_ready on cycle 4 -> resp_valid, no err.
//  6. rst low in BUSY (mid-cycle) -> mem_req/stall fall immediately; after release,
//     a new sb succeeds normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage load/store controller with valid/ready memory handshake,
//            store lane replication, load byte alignment and timeout.
// Revision : 1.0
// ============================================================================
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic        o_err,
  output logic [31:0] o_ld_data,
  output logic [2:0]  o_ld_func3,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

  state_t        r_state, w_nxt;
  logic [29:0]   r_waddr;
  logic [1:0]    r_off;
  logic [2:0]    r_func3;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_ld_data;
  logic [2:0]    r_ld_func3;
  logic          r_err;

  logic          w_illegal, w_misal, w_accept, w_reject, w_busy, w_xfer, w_tmo;
  logic [3:0]    w_strb;
  logic [31:0]   w_lane;

  always_comb begin
    w_illegal = (i_func3 == 3'b011) || (i_func3[2:1] == 2'b11) || (i_is_store && i_func3[2]);
    w_misal   = ((i_func3[1:0] == 2'b01) && i_addr[0]) ||
                ((i_func3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    w_accept  = (r_state == S_IDLE) && i_req_valid && !w_illegal && !w_misal;
    w_reject  = (r_state == S_IDLE) && i_req_valid && (w_illegal || w_misal);
    w_busy    = (r_state == S_BUSY);
    w_xfer    = w_busy && i_mem_ready;
    w_tmo     = w_busy && !i_mem_ready && (TIMEOUT_CYC != 0) && (r_cnt == CW'(TIMEOUT_CYC));
  end

  // Store lanes are resolved at acceptance so BUSY drives purely registered values
  always_comb begin
    w_strb = 4'b0000;
    w_lane = i_wdata;
    if (i_is_store) begin
      case (i_func3[1:0])
        2'b00:   begin w_strb = 4'b0001 << i_addr[1:0]; w_lane = {4{i_wdata[7:0]}};  end
        2'b01:   begin w_strb = 4'b0011 << i_addr[1:0]; w_lane = {2{i_wdata[15:0]}}; end
        default: begin w_strb = 4'b1111;                w_lane = i_wdata;            end
      endcase
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nxt = S_BUSY;
      S_BUSY:  begin
        if (w_xfer)     w_nxt = S_RESP;
        else if (w_tmo) w_nxt = S_IDLE;
      end
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_waddr    <= '0;
      r_off      <= '0;
      r_func3    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_cnt      <= '0;
      r_ld_data  <= '0;
      r_ld_func3 <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_reject || w_tmo;
      if (w_accept) begin
        r_waddr <= i_addr[31:2];
        r_off   <= i_addr[1:0];
        r_func3 <= i_func3;
        r_we    <= i_is_store;
        r_wdata <= w_lane;
        r_wstrb <= w_strb;
        r_cnt   <= CW'(1);
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_xfer && !r_we) begin
        r_ld_data  <= i_mem_rdata >> {r_off, 3'b000};
        r_ld_func3 <= r_func3;
      end
    end
  end

  assign o_stall      = w_accept || w_busy;
  assign o_resp_valid = (r_state == S_RESP);
  assign o_err        = r_err;
  assign o_ld_data    = r_ld_data;
  assign o_ld_func3   = r_ld_func3;
  assign o_mem_req    = w_busy;
  assign o_mem_we     = w_busy && r_we;
  assign o_mem_addr   = w_busy ? {r_waddr, 2'b00} : 32'h0;
  assign o_mem_wdata  = w_busy ? r_wdata : 32'h0;
  assign o_mem_wstrb  = w_busy ? r_wstrb : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed vector table plus timeout / reset sequences.
// Revision : 1.0
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, is_load, is_store, mem_ready;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, resp_valid, err, mem_req, mem_we;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic [2:0]  ld_func3;
  logic [3:0]  mem_wstrb;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_is_load(is_load),
    .i_is_store(is_store), .i_func3(func3), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_resp_valid(resp_valid), .o_err(err), .o_ld_data(ld_data),
    .o_ld_func3(ld_func3), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e_err;
    logic [31:0] e_maddr;
    logic [3:0]  e_strb;
    logic [31:0] e_mwd;
    logic [31:0] e_ld;
    logic [2:0]  e_f3;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1; is_load = v.ld; is_store = !v.ld;
    func3 = v.f3; addr = v.a; wdata = v.wd;
    #1 chk("stall_accept", {31'b0, stall}, {31'b0, !v.e_err});
    @(negedge clk);
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    if (v.e_err) begin
      #1;
      chk("err_pulse", {31'b0, err}, 32'd1);
      chk("err_no_req", {31'b0, mem_req}, 32'd0);
      chk("err_no_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      #1 chk("err_one_cycle", {31'b0, err}, 32'd0);
    end else begin
      #1;
      chk("busy_req", {31'b0, mem_req}, 32'd1);
      chk("busy_stall", {31'b0, stall}, 32'd1);
      chk("busy_we", {31'b0, mem_we}, {31'b0, !v.ld});
      chk("busy_addr", mem_addr, v.e_maddr);
      chk("busy_strb", {28'b0, mem_wstrb}, {28'b0, v.e_strb});
      if (!v.ld) chk("busy_wdata", mem_wdata, v.e_mwd);
      mem_ready = 1'b1; mem_rdata = v.rd;
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = 32'h0;
      #1;
      chk("resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("resp_stall", {31'b0, stall}, 32'd0);
      chk("resp_noerr", {31'b0, err}, 32'd0);
      chk("resp_noreq", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      #1 chk("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    end
    chk("ld_data", ld_data, v.e_ld);
    chk("ld_func3", {29'b0, ld_func3}, {29'b0, v.e_f3});
  endtask

  // Fields: ld f3 addr wdata rdata | err maddr strb mwdata ld_data ld_f3
  function automatic vec_t mk(input logic l, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic e,
                              input logic [31:0] ma, input logic [3:0] s, input logic [31:0] mw,
                              input logic [31:0] ld, input logic [2:0] lf);
    vec_t v;
    v.ld = l; v.f3 = f; v.a = a; v.wd = wd; v.rd = rd; v.e_err = e;
    v.e_maddr = ma; v.e_strb = s; v.e_mwd = mw; v.e_ld = ld; v.e_f3 = lf;
    return v;
  endfunction

  initial begin
    int cyc;
    vecs[0]  = mk(1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 32'h100, 4'b0000, 0, 32'hDEADBEEF, 3'b010);
    vecs[1]  = mk(1, 3'b100, 32'h103, 0, 32'h80AA5511, 0, 32'h100, 4'b0000, 0, 32'h00000080, 3'b100);
    vecs[2]  = mk(0, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080, 3'b100);
    vecs[3]  = mk(1, 3'b010, 32'h101, 0, 0, 1, 0, 0, 0, 32'h00000080, 3'b100);
    vecs[4]  = mk(0, 3'b000, 32'h301, 32'h12345677, 0, 0, 32'h300, 4'b0010, 32'h77777777, 32'h00000080, 3'b100);
    vecs[5]  = mk(1, 3'b001, 32'h106, 0, 32'hCAFE1234, 0, 32'h104, 4'b0000, 0, 32'h0000CAFE, 3'b001);
    vecs[6]  = mk(0, 3'b010, 32'h010, 32'h11223344, 0, 0, 32'h010, 4'b1111, 32'h11223344, 32'h0000CAFE, 3'b001);
    vecs[7]  = mk(0, 3'b100, 32'h020, 32'h5, 0, 1, 0, 0, 0, 32'h0000CAFE, 3'b001);
    vecs[8]  = mk(1, 3'b011, 32'h020, 0, 0, 1, 0, 0, 0, 32'h0000CAFE, 3'b001);
    vecs[9]  = mk(1, 3'b101, 32'h203, 0, 0, 1, 0, 0, 0, 32'h0000CAFE, 3'b001);
    vecs[10] = mk(1, 3'b000, 32'h002, 0, 32'h00FF0000, 0, 32'h000, 4'b0000, 0, 32'h000000FF, 3'b000);
    vecs[11] = mk(0, 3'b010, 32'h012, 32'h1, 0, 1, 0, 0, 0, 32'h000000FF, 3'b000);

    rst_n = 1'b0; req_valid = 0; is_load = 0; is_store = 0; func3 = 0;
    addr = 0; wdata = 0; mem_ready = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {stall, resp_valid, err, mem_req, mem_we, mem_wstrb}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_func3", {29'b0, ld_func3}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Timeout: lh with memory never ready keeps mem_req for exactly 4 cycles
    @(negedge clk);
    req_valid = 1; is_load = 1; func3 = 3'b001; addr = 32'h40;
    @(negedge clk);
    req_valid = 0; is_load = 0;
    cyc = 0;
    #1;
    while (mem_req && cyc < 10) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("tmo_req_cycles", cyc, 32'd4);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("tmo_ld_kept", ld_data, 32'h000000FF);

    // Ready arriving in the timeout cycle wins
    @(negedge clk);
    req_valid = 1; is_load = 1; func3 = 3'b001; addr = 32'h42;
    @(negedge clk);
    req_valid = 0; is_load = 0;
    repeat (3) @(negedge clk);
    #1 chk("late_req_still", {31'b0, mem_req}, 32'd1);
    mem_ready = 1; mem_rdata = 32'h5678ABCD;
    @(negedge clk);
    mem_ready = 0; mem_rdata = 0;
    #1;
    chk("late_resp", {31'b0, resp_valid}, 32'd1);
    chk("late_noerr", {31'b0, err}, 32'd0);
    chk("late_ld", ld_data, 32'h00005678);
    @(negedge clk);
    #1 chk("late_noerr2", {31'b0, err}, 32'd0);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    req_valid = 1; is_load = 1; func3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    req_valid = 0; is_load = 0;
    #1 chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rst_stall_drop", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ld", ld_data, 32'd0);
    chk("post_rst_req", {31'b0, mem_req}, 32'd0);
    run_op(mk(0, 3'b000, 32'h83, 32'h000000A5, 0, 0, 32'h80, 4'b1000, 32'hA5A5A5A5, 32'h0, 3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
